// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: depth-parametrised hazard unit.
// Tracks in-flight writers from Execute on; drives stalls, flushes and forwards.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int MDU_LAT = 4,
  parameter int FW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_uses_rs,
  input  logic              d_uses_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic              d_regwrite,
  input  logic              d_load,
  input  logic              d_branch,
  input  logic              d_pcsrc,
  input  logic              d_mdu_start,
  input  logic              d_mdu_read,
  output logic              stall_f,
  output logic              stall_d,
  output logic              clr_d,
  output logic              flush_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [FW-1:0]     fwd_a_e,
  output logic [FW-1:0]     fwd_b_e,
  output logic              mdu_busy
);

  localparam int CW = $clog2(MDU_LAT + 1);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              load;
    logic              mdu;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } slot_t;

  slot_t          sb [DEPTH];
  logic [DEPTH-1:0] wr;
  logic [CW-1:0]  cnt;
  logic           haz_rs;
  logic           haz_rt;
  logic           haz_mdu;
  logic           stall;
  logic           unused_bits;

  // Load-use, branch-ALU and branch-load hazard for one Decode source.
  function automatic logic src_haz(
    input logic              use_s,
    input logic [REG_AW-1:0] s,
    input slot_t             e0,
    input slot_t             e1,
    input logic              w0,
    input logic              w1,
    input logic              br
  );
    return use_s && (s != '0) &&
      ((w0 && (e0.dst == s) && (e0.load || br)) ||
       (br && w1 && e1.load && (e1.dst == s)));
  endfunction

  // Writer flag per slot: valid, writes a register, and not r0.
  always_comb begin
    wr = '0;
    for (int k = 0; k < DEPTH; k++)
      wr[k] = sb[k].valid & sb[k].regwrite & (sb[k].dst != '0);
  end

  // Stall detection and stall/clear outputs, silenced during reset.
  always_comb begin
    haz_rs  = src_haz(d_uses_rs, d_rs, sb[0], sb[1], wr[0], wr[1], d_branch);
    haz_rt  = src_haz(d_uses_rt, d_rt, sb[0], sb[1], wr[0], wr[1], d_branch);
    haz_mdu = (d_mdu_start | d_mdu_read) & mdu_busy;
    stall   = haz_rs | haz_rt | haz_mdu;
    stall_f = stall & ~rst;
    stall_d = stall & ~rst;
    flush_e = stall & ~rst;
    clr_d   = d_pcsrc & ~stall & ~rst;
  end

  // Decode-comparator forwarding from an ALU result sitting in M.
  always_comb begin
    fwd_a_d = (d_rs != '0) & wr[1] & ~sb[1].load & (sb[1].dst == d_rs);
    fwd_b_d = (d_rt != '0) & wr[1] & ~sb[1].load & (sb[1].dst == d_rt);
  end

  // Execute forwarding: youngest matching writer wins, so scan old to young.
  always_comb begin
    fwd_a_e = '0;
    fwd_b_e = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (wr[k] && (sb[0].rs != '0) && (sb[k].dst == sb[0].rs))
        fwd_a_e = FW'(k);
      if (wr[k] && (sb[0].rt != '0) && (sb[k].dst == sb[0].rt))
        fwd_b_e = FW'(k);
    end
  end

  // Fields kept for the datapath but not consumed by the hazard logic.
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      unused_bits = unused_bits ^ (^sb[k]);
  end

  assign mdu_busy = (cnt != '0);

  // Scoreboard shift: Decode enters slot 0, or a bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        sb[k] <= '0;
    end else begin
      if (stall)
        sb[0] <= '0;
      else
        sb[0] <= '{valid:    1'b1,
                   regwrite: d_regwrite,
                   load:     d_load,
                   mdu:      d_mdu_start,
                   dst:      d_dst,
                   rs:       d_rs,
                   rt:       d_rt};
      for (int k = 1; k < DEPTH; k++)
        sb[k] <= sb[k-1];
    end
  end

  // MDU busy counter: reload on an accepted mult/div, else count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!stall && d_mdu_start)
      cnt <= CW'(MDU_LAT);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors for hazard_scoreboard.
// Default parameters: REG_AW=5, DEPTH=3, MDU_LAT=4.
module tb_hazard_scoreboard;

  localparam logic [7:0] URS = 8'h01;
  localparam logic [7:0] URT = 8'h02;
  localparam logic [7:0] RW  = 8'h04;
  localparam logic [7:0] LD  = 8'h08;
  localparam logic [7:0] BR  = 8'h10;
  localparam logic [7:0] PC  = 8'h20;
  localparam logic [7:0] MS  = 8'h40;
  localparam logic [7:0] MR  = 8'h80;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_rs, d_rt, d_dst;
  logic       d_uses_rs, d_uses_rt, d_regwrite, d_load;
  logic       d_branch, d_pcsrc, d_mdu_start, d_mdu_read;
  logic       stall_f, stall_d, clr_d, flush_e;
  logic       fwd_a_d, fwd_b_d, mdu_busy;
  logic [1:0] fwd_a_e, fwd_b_e;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_uses_rs   (d_uses_rs),
    .d_uses_rt   (d_uses_rt),
    .d_dst       (d_dst),
    .d_regwrite  (d_regwrite),
    .d_load      (d_load),
    .d_branch    (d_branch),
    .d_pcsrc     (d_pcsrc),
    .d_mdu_start (d_mdu_start),
    .d_mdu_read  (d_mdu_read),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .clr_d       (clr_d),
    .flush_e     (flush_e),
    .fwd_a_d     (fwd_a_d),
    .fwd_b_d     (fwd_b_d),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .mdu_busy    (mdu_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic stl(input string tag, input logic e);
    chk({tag, "_sf"}, 32'(stall_f), 32'(e));
    chk({tag, "_sd"}, 32'(stall_d), 32'(e));
    chk({tag, "_fe"}, 32'(flush_e), 32'(e));
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] dst, input logic [7:0] f);
    d_rs        = rs;
    d_rt        = rt;
    d_dst       = dst;
    d_uses_rs   = f[0];
    d_uses_rt   = f[1];
    d_regwrite  = f[2];
    d_load      = f[3];
    d_branch    = f[4];
    d_pcsrc     = f[5];
    d_mdu_start = f[6];
    d_mdu_read  = f[7];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, PC);
    stl("rst", 1'b0);
    chk("rst_clr", 32'(clr_d), 0);
    chk("rst_busy", 32'(mdu_busy), 0);
    chk("rst_fae", 32'(fwd_a_e), 0);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 0, 0);
    tick();

    // load-use: lw $2 then add $3,$2,$4
    drv(1, 0, 2, URS | RW | LD);
    tick();
    drv(2, 4, 3, URS | URT | RW);
    stl("lu_on", 1'b1);
    chk("lu_clr", 32'(clr_d), 0);
    tick();
    stl("lu_off", 1'b0);
    chk("lu_fad", 32'(fwd_a_d), 0);
    tick();
    drv(0, 0, 0, 0);
    chk("lu_fae", 32'(fwd_a_e), 2);
    chk("lu_fbe", 32'(fwd_b_e), 0);
    tick();

    // E forwarding priority on $5
    drv(0, 0, 5, RW);
    tick();
    drv(0, 0, 5, RW);
    tick();
    drv(5, 0, 0, URS);
    chk("pr_fad", 32'(fwd_a_d), 1);
    stl("pr_go", 1'b0);
    tick();
    drv(0, 0, 5, RW);
    chk("pr_k1", 32'(fwd_a_e), 1);
    tick();
    drv(0, 0, 0, RW);
    tick();
    drv(5, 0, 0, URS);
    tick();
    drv(0, 0, 6, RW | LD);
    chk("pr_k2", 32'(fwd_a_e), 2);
    tick();
    drv(6, 6, 0, 0);
    stl("nouse", 1'b0);
    tick();
    drv(0, 0, 0, 0);
    chk("ld1_fae", 32'(fwd_a_e), 1);
    chk("ld1_fbe", 32'(fwd_b_e), 1);
    tick();

    // branch on an ALU result in E, taken
    drv(0, 0, 7, RW);
    tick();
    drv(7, 0, 0, URS | URT | BR | PC);
    stl("br_on", 1'b1);
    chk("br_clr0", 32'(clr_d), 0);
    tick();
    stl("br_off", 1'b0);
    chk("br_fad", 32'(fwd_a_d), 1);
    chk("br_fbd", 32'(fwd_b_d), 0);
    chk("br_clr", 32'(clr_d), 1);
    drv(0, 0, 0, 0);
    tick();

    // branch on a load: two stall cycles
    drv(0, 0, 9, RW | LD);
    tick();
    drv(9, 0, 0, URS | URT | BR);
    stl("bl_1", 1'b1);
    tick();
    stl("bl_2", 1'b1);
    tick();
    stl("bl_3", 1'b0);
    drv(0, 0, 0, 0);
    tick();

    // r0 is never a hazard
    drv(0, 0, 0, RW | LD);
    tick();
    drv(0, 0, 0, URS | URT | BR);
    stl("r0", 1'b0);
    chk("r0_fad", 32'(fwd_a_d), 0);
    chk("r0_fbd", 32'(fwd_b_d), 0);
    tick();
    drv(0, 0, 0, 0);
    chk("r0_fae", 32'(fwd_a_e), 0);
    chk("r0_fbe", 32'(fwd_b_e), 0);
    tick();

    // mult then mflo: 4 stall cycles
    drv(10, 11, 0, URS | URT | MS);
    chk("mdu_idle", 32'(mdu_busy), 0);
    stl("mdu_go", 1'b0);
    tick();
    drv(0, 0, 12, RW | MR);
    for (int i = 0; i < 4; i++) begin
      chk("mdu_busy", 32'(mdu_busy), 1);
      stl("mdu_hold", 1'b1);
      tick();
    end
    chk("mdu_done", 32'(mdu_busy), 0);
    stl("mdu_rel", 1'b0);
    drv(0, 0, 0, 0);
    tick();

    // reset while the MDU counter is at 2
    drv(10, 11, 0, URS | URT | MS);
    tick();
    drv(0, 0, 14, RW);
    tick();
    drv(0, 0, 13, RW | LD);
    tick();
    drv(0, 0, 12, RW | MR);
    chk("rm_busy", 32'(mdu_busy), 1);
    stl("rm_stall", 1'b1);
    rst = 1'b1;
    #1;
    chk("rm_busy0", 32'(mdu_busy), 0);
    stl("rm_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drv(13, 14, 0, URS | URT | BR);
    stl("rm_after", 1'b0);
    chk("rm_fbd", 32'(fwd_b_d), 0);
    tick();
    drv(0, 0, 0, 0);
    chk("rm_fae", 32'(fwd_a_e), 0);
    chk("rm_fbe", 32'(fwd_b_e), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
